// File: rtl/booth_mult_sequencer_if.sv
// rtl/booth_mult_sequencer_if.sv - operand/product handshake and multiplier-side bundle
interface booth_mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_a;
    logic [WIDTH-1:0]      in_b;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic                  mul_en;
    logic [2*WIDTH-1:0]    mul_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*WIDTH-1:0]    out_product;
    logic                  busy;

    modport slave (
        input  in_valid, in_a, in_b, mul_result, out_ready,
        output in_ready, mul_a, mul_b, mul_en, out_valid, out_product, busy
    );

    modport master (
        output in_valid, in_a, in_b, mul_result, out_ready,
        input  in_ready, mul_a, mul_b, mul_en, out_valid, out_product, busy
    );
endinterface

// File: rtl/booth_mult_sequencer.sv
// rtl/booth_mult_sequencer.sv - sequences one multiply at a time through a fixed-latency multiplier
// and buffers products in a 2-entry FIFO.
module booth_mult_sequencer #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 33
) (
    input  logic                  clk,
    input  logic                  reset,
    booth_mult_sequencer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0]   fifo_q [2];
    logic [2*WIDTH-1:0]   fifo_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           fcount_q, fcount_d;

    logic accept;
    logic push;
    logic pop;

    // in_ready is masked by reset so upstream never sees a ready sequencer while it is held.
    assign bus.in_ready    = !reset && (state_q == IDLE) && (fcount_q < 2'd2);
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.mul_en      = (state_q == RUN);
    assign bus.busy        = (state_q == RUN);
    assign bus.out_valid   = (fcount_q != 2'd0);
    assign bus.out_product = (fcount_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        push     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mul_a_d = bus.in_a;
                    mul_b_d = bus.in_b;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Push writes the free slot while pop advances the head, so a same-edge push/pop keeps order.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcount_d = fcount_q;

        if (push) begin
            fifo_d[wr_ptr_q] = bus.mul_result;
            wr_ptr_d         = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        if (push && !pop) begin
            fcount_d = fcount_q + 2'd1;
        end else if (pop && !push) begin
            fcount_d = fcount_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            fcount_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fcount_q  <= fcount_d;
        end
    end
endmodule

// File: tb/tb_booth_mult_sequencer.sv
// tb/tb_booth_mult_sequencer.sv - directed bench with a registered fixed-latency multiplier model
module tb_booth_mult_sequencer;
    localparam int WIDTH   = 32;
    localparam int LATENCY = 33;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    booth_mult_sequencer_if #(.WIDTH(WIDTH)) bus ();

    booth_mult_sequencer #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: LATENCY-1 register stages, so the product of operands loaded at edge E
    // is present on mul_result exactly when the sequencer samples it at edge E+LATENCY.
    logic signed [2*WIDTH-1:0] pipe [LATENCY-1];
    always @(posedge clk) begin
        pipe[0] <= $signed(bus.mul_a) * $signed(bus.mul_b);
        for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mul_result = pipe[LATENCY-2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
        int n;
        int hold_bad;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        hold_bad = 0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            if (bus.mul_en && (bus.mul_a !== a || bus.mul_b !== b)) hold_bad++;
            bus.in_a = $urandom;
            bus.in_b = $urandom;
            tick();
            n++;
        end
        chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        chk(tag, bus.out_product, exp);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int           n_en;
        logic         ov32, ov33;
        logic [63:0]  prod;
        int           late;

        tests = 0;
        fails = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        tick();
        tick();
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mul_en",    64'(bus.mul_en),    64'd0);
        chk("rst_mul_a",     64'(bus.mul_a),     64'd0);
        chk("rst_product",   bus.out_product,    64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // Single op with exact timing
        bus.in_a     = 32'd553524;
        bus.in_b     = 32'd840;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_en = 0;
        ov32 = 1'b0;
        ov33 = 1'b0;
        prod = '0;
        for (int k = 0; k < 40; k++) begin
            if (bus.mul_en) n_en++;
            if (bus.busy !== bus.mul_en) n_en = 1000;
            if (k == 32) ov32 = bus.out_valid;
            if (k == 33) begin
                ov33 = bus.out_valid;
                prod = bus.out_product;
            end
            tick();
        end
        chk("single_en_cycles", 64'(n_en), 64'd33);
        chk("single_ov_E32",    64'(ov32), 64'd0);
        chk("single_ov_E33",    64'(ov33), 64'd1);
        chk("single_product",   prod,      64'd464960160);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("single_popped", 64'(bus.out_valid), 64'd0);

        // Signed products with operand toggling while busy
        run_op(32'd553524,            32'hFFFFFEFD,  64'($signed(-64'sd143362716)), "s_pos_neg");
        run_op(32'hFFFFFEFD,          32'hFFFFFEFD,  64'd67081,                    "s_neg_neg");
        run_op(32'(-32'sd1199060305), 32'd0,         64'd0,                        "s_zero");
        run_op(32'd1,                 32'd1348760118, 64'd1348760118,              "s_one");

        // Backpressure: two buffered products, third op stalled until a pop
        run_op_nopop: begin
            bus.in_a = 32'd3;  bus.in_b = 32'd5;  bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            wait_out("bp_first");
            chk("bp_ready_after_1", 64'(bus.in_ready), 64'd1);
            bus.in_a = 32'hFFFFFFF9; bus.in_b = 32'd9; bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            for (int k = 0; k < LATENCY + 2; k++) tick();
            chk("bp_fcount2",  64'(dut.fcount_q), 64'd2);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            bus.in_a = 32'd100; bus.in_b = 32'd100; bus.in_valid = 1'b1;
            for (int k = 0; k < 5; k++) tick();
            chk("bp_stalled",  64'(bus.mul_en),     64'd0);
            chk("bp_head0",    bus.out_product,     64'd15);
            bus.out_ready = 1'b1;
            tick();
            chk("bp_head1",     bus.out_product,    64'($signed(-64'sd63)));
            chk("bp_not_yet",   64'(bus.mul_en),    64'd0);
            tick();
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            chk("bp_third_acc", 64'(bus.mul_en),    64'd1);
            chk("bp_third_a",   64'(bus.mul_a),     64'd100);
            chk("bp_empty",     64'(bus.out_valid), 64'd0);
            wait_out("bp_third");
            chk("bp_third_prod", bus.out_product,   64'd10000);
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end

        // Simultaneous push and pop on the capture edge
        bus.in_a = 32'd11; bus.in_b = 32'd13; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out("pp_first");
        tick();
        bus.in_a = 32'hFFFFFFFE; bus.in_b = 32'd50; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < LATENCY - 1; k++) tick();
        chk("pp_head_before", bus.out_product, 64'd143);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pp_fcount",    64'(dut.fcount_q), 64'd1);
        chk("pp_head_after", bus.out_product,  64'($signed(-64'sd100)));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pp_drained", 64'(bus.out_valid), 64'd0);

        // Reset mid-RUN with a buffered product present
        bus.in_a = 32'd2; bus.in_b = 32'd3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out("rm_buffered");
        bus.in_a = 32'd7; bus.in_b = 32'd7; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rm_mul_en",    64'(bus.mul_en),    64'd0);
        chk("rm_busy",      64'(bus.busy),      64'd0);
        chk("rm_mul_a",     64'(bus.mul_a),     64'd0);
        chk("rm_mul_b",     64'(bus.mul_b),     64'd0);
        chk("rm_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rm_product",   bus.out_product,    64'd0);
        chk("rm_in_ready",  64'(bus.in_ready),  64'd0);
        tick();
        reset = 1'b0;
        late = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.out_valid || bus.mul_en) late++;
            tick();
        end
        chk("rm_no_late_product", 64'(late), 64'd0);
        run_op(32'd123, 32'hFFFFFE38, 64'($signed(-64'sd56088)), "rm_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
